// File: rtl/shire_dma_pkg.sv
// Shared definitions for the DMA descriptor scheduler: FSM encoding and slot-entry field widths.
package shire_dma_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // Slot entry holds the owning port index (up to 8 requesters) and the requester tag.
    localparam int unsigned MAX_PORTS     = 8;
    localparam int unsigned SLOT_PORT_W   = 3;
    localparam int unsigned SLOT_VALID_W  = 1;

    function automatic logic [SLOT_PORT_W-1:0] rr_next(
        input logic [SLOT_PORT_W-1:0] idx,
        input int unsigned            ports
    );
        return (32'(idx) + 32'd1 >= ports) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over PORTS requesters; search starts at the registered pointer.
module rr_arbiter
    import shire_dma_pkg::*;
#(
    parameter int unsigned PORTS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PORTS-1:0]       req,
    input  logic                   advance,
    output logic [PORTS-1:0]       grant,
    output logic                   grant_valid,
    output logic [SLOT_PORT_W-1:0] grant_idx
);

    logic [SLOT_PORT_W-1:0] ptr;
    int unsigned            cand;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < PORTS; i++) begin
            cand = (32'(ptr) + i) % PORTS;
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = SLOT_PORT_W'(cand);
            end
        end
    end

    // Pointer holds the port with highest priority next time, i.e. one past the last grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= rr_next(grant_idx, PORTS);
        end
    end

endmodule

// File: rtl/dma_desc_sched.sv
// Multi-port DMA descriptor scheduler with tag remapping through a slot table.
// Optional per-port issue counters: define DMA_DESC_SCHED_STATS_EN.
module dma_desc_sched
    import shire_dma_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 20,
    parameter int unsigned TAG_WIDTH  = 8,
    parameter int unsigned SLOTS      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [PORTS*LEN_WIDTH-1:0]  req_len,
    input  logic [PORTS*TAG_WIDTH-1:0]  req_tag,
    input  logic [PORTS-1:0]            req_valid,
    output logic [PORTS-1:0]            req_ready,
    output logic [ADDR_WIDTH-1:0]       m_desc_addr,
    output logic [LEN_WIDTH-1:0]        m_desc_len,
    output logic [TAG_WIDTH-1:0]        m_desc_tag,
    output logic                        m_desc_valid,
    input  logic                        m_desc_ready,
    input  logic [TAG_WIDTH-1:0]        s_status_tag,
    input  logic                        s_status_valid,
    output logic [PORTS*TAG_WIDTH-1:0]  resp_tag,
    output logic [PORTS-1:0]            resp_valid,
    output logic                        err_unknown_tag,
    output logic                        busy
`ifdef DMA_DESC_SCHED_STATS_EN
    ,
    output logic [PORTS*16-1:0]         stat_issued
`endif
);

    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t                 state;
    logic [SLOTS-1:0]       slot_alloc;
    logic [SLOT_PORT_W-1:0] slot_port [SLOTS];
    logic [TAG_WIDTH-1:0]   slot_tag  [SLOTS];

    logic                   any_free;
    logic [SLOT_W-1:0]      free_idx;
    logic [PORTS-1:0]       arb_req;
    logic [PORTS-1:0]       grant;
    logic                   grant_valid;
    logic [SLOT_PORT_W-1:0] grant_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic [TAG_WIDTH-1:0]   sel_tag;
    logic                   st_in_range;
    logic [SLOT_W-1:0]      st_idx;
    logic                   st_hit;

    // Lowest free slot from the registered table, so a slot freed this cycle is not reused.
    always_comb begin
        any_free = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!slot_alloc[i] && !any_free) begin
                any_free = 1'b1;
                free_idx = SLOT_W'(i);
            end
        end
    end

    assign arb_req = (rst_n && state == ST_IDLE && any_free) ? req_valid : '0;

    rr_arbiter #(.PORTS(PORTS)) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (arb_req),
        .advance     (grant_valid),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign req_ready = grant;
    assign busy      = |slot_alloc;

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        sel_tag  = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            if (grant[p]) begin
                sel_addr = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = req_len[p*LEN_WIDTH +: LEN_WIDTH];
                sel_tag  = req_tag[p*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign st_in_range = {1'b0, s_status_tag} < (TAG_WIDTH+1)'(SLOTS);
    assign st_idx      = s_status_tag[SLOT_W-1:0];
    assign st_hit      = s_status_valid && st_in_range && slot_alloc[st_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            slot_alloc      <= '0;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slot_port[i] <= '0;
                slot_tag[i]  <= '0;
            end
            m_desc_addr     <= '0;
            m_desc_len      <= '0;
            m_desc_tag      <= '0;
            m_desc_valid    <= 1'b0;
            resp_valid      <= '0;
            resp_tag        <= '0;
            err_unknown_tag <= 1'b0;
        end else begin
            resp_valid <= '0;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        slot_alloc[free_idx] <= 1'b1;
                        slot_port[free_idx]  <= grant_idx;
                        slot_tag[free_idx]   <= sel_tag;
                        m_desc_addr          <= sel_addr;
                        m_desc_len           <= sel_len;
                        m_desc_tag           <= TAG_WIDTH'(free_idx);
                        m_desc_valid         <= 1'b1;
                        state                <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_desc_ready) begin
                        m_desc_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Completion: an allocated slot is never the one being allocated, so no index clash.
            if (s_status_valid) begin
                if (st_hit) begin
                    slot_alloc[st_idx] <= 1'b0;
                    for (int unsigned p = 0; p < PORTS; p++) begin
                        if (SLOT_PORT_W'(p) == slot_port[st_idx]) begin
                            resp_valid[p]                        <= 1'b1;
                            resp_tag[p*TAG_WIDTH +: TAG_WIDTH]   <= slot_tag[st_idx];
                        end
                    end
                end else begin
                    err_unknown_tag <= 1'b1;
                end
            end
        end
    end

`ifdef DMA_DESC_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued <= '0;
        end else if (grant_valid) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (grant[p] && stat_issued[p*16 +: 16] != 16'hFFFF) begin
                    stat_issued[p*16 +: 16] <= stat_issued[p*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched with descriptor and response scoreboards.
module tb_dma_desc_sched;

    localparam int unsigned P  = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned LW = 20;
    localparam int unsigned TW = 8;
    localparam int unsigned S  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [P*AW-1:0] req_addr;
    logic [P*LW-1:0] req_len;
    logic [P*TW-1:0] req_tag;
    logic [P-1:0]    req_valid;
    logic [P-1:0]    req_ready;
    logic [AW-1:0]   m_desc_addr;
    logic [LW-1:0]   m_desc_len;
    logic [TW-1:0]   m_desc_tag;
    logic            m_desc_valid;
    logic            m_desc_ready;
    logic [TW-1:0]   s_status_tag;
    logic            s_status_valid;
    logic [P*TW-1:0] resp_tag;
    logic [P-1:0]    resp_valid;
    logic            err_unknown_tag;
    logic            busy;
`ifdef DMA_DESC_SCHED_STATS_EN
    logic [P*16-1:0] stat_issued;
`endif

    dma_desc_sched #(
        .PORTS(P), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW), .SLOTS(S)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_tag         (req_tag),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .m_desc_addr     (m_desc_addr),
        .m_desc_len      (m_desc_len),
        .m_desc_tag      (m_desc_tag),
        .m_desc_valid    (m_desc_valid),
        .m_desc_ready    (m_desc_ready),
        .s_status_tag    (s_status_tag),
        .s_status_valid  (s_status_valid),
        .resp_tag        (resp_tag),
        .resp_valid      (resp_valid),
        .err_unknown_tag (err_unknown_tag),
        .busy            (busy)
`ifdef DMA_DESC_SCHED_STATS_EN
        ,
        .stat_issued     (stat_issued)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [TW-1:0] tag;
    } desc_t;

    typedef struct {
        int unsigned   port;
        logic [TW-1:0] tag;
    } resp_t;

    desc_t exp_desc[$];
    resp_t exp_resp[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic monitor();
        desc_t d;
        resp_t r;
        if (m_desc_valid && m_desc_ready) begin
            if (exp_desc.size() == 0) begin
                chk("desc_unexpected", 64'(m_desc_valid), 64'd0);
            end else begin
                d = exp_desc.pop_front();
                chk("desc_addr", 64'(m_desc_addr), 64'(d.addr));
                chk("desc_len",  64'(m_desc_len),  64'(d.len));
                chk("desc_tag",  64'(m_desc_tag),  64'(d.tag));
            end
        end
        for (int p = 0; p < P; p++) begin
            if (resp_valid[p]) begin
                if (exp_resp.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid[p]), 64'd0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_port", 64'(p), 64'(r.port));
                    chk("resp_tag",  64'(resp_tag[p*TW +: TW]), 64'(r.tag));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [TW-1:0] t);
        req_addr[p*AW +: AW] = a;
        req_len[p*LW +: LW]  = l;
        req_tag[p*TW +: TW]  = t;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_m_desc_valid"}, 64'(m_desc_valid), 64'd0);
        chk({name, "_req_ready"},    64'(req_ready),    64'd0);
        chk({name, "_resp_valid"},   64'(resp_valid),   64'd0);
        chk({name, "_busy"},         64'(busy),         64'd0);
        chk({name, "_err"},          64'(err_unknown_tag), 64'd0);
        chk({name, "_desc_fields"},  {m_desc_addr, m_desc_len, m_desc_tag}, 64'd0);
        chk({name, "_resp_tag"},     64'(resp_tag),     64'd0);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        check_zero(name);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input int p, input logic [AW-1:0] a, input logic [LW-1:0] l,
                        input logic [TW-1:0] t, input logic [TW-1:0] slot);
        set_req(p, a, l, t);
        req_valid = P'(1 << p);
        #1;
        chk("send_grant", 64'(req_ready), 64'(1 << p));
        exp_desc.push_back('{a, l, slot});
        tick();
        req_valid = '0;
        chk("send_desc_valid", 64'(m_desc_valid), 64'd1);
        tick();
    endtask

    task automatic status(input logic [TW-1:0] t);
        s_status_tag   = t;
        s_status_valid = 1'b1;
        tick();
        s_status_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        req_addr       = '0;
        req_len        = '0;
        req_tag        = '0;
        req_valid      = 4'hF;
        m_desc_ready   = 1'b1;
        s_status_tag   = '0;
        s_status_valid = 1'b0;
        #1;
        check_zero("reset");
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single request on port 2
        set_req(2, 16'h0100, 20'd64, 8'h5A);
        req_valid = 4'b0100;
        #1;
        chk("t1_req_ready", 64'(req_ready), 64'b0100);
        exp_desc.push_back('{16'h0100, 20'd64, 8'h00});
        tick();
        req_valid = '0;
        chk("t1_desc_valid", 64'(m_desc_valid), 64'd1);
        chk("t1_issue_ready_low", 64'(req_ready), 64'd0);
        tick();
        chk("t1_desc_dropped", 64'(m_desc_valid), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        exp_resp.push_back('{2, 8'h5A});
        status(8'h00);
        chk("t1_resp_pulse", 64'(resp_valid), 64'b0100);
        chk("t1_resp_tag", 64'(resp_tag[2*TW +: TW]), 64'h5A);
        tick();
        chk("t1_resp_once", 64'(resp_valid), 64'd0);
        chk("t1_busy_clear", 64'(busy), 64'd0);
        chk("t1_resp_tag_hold", 64'(resp_tag[2*TW +: TW]), 64'h5A);

        // All ports valid: round-robin 0..3 then stall on full slots
        do_reset("t2_reset");
        for (int p = 0; p < P; p++) begin
            set_req(p, AW'(16'h1000 + p), LW'(p * 3), TW'(8'hA0 + p));
            exp_desc.push_back('{AW'(16'h1000 + p), LW'(p * 3), TW'(p)});
        end
        req_valid = 4'hF;
        for (int k = 0; k < P; k++) begin
            #1;
            chk("t2_grant_order", 64'(req_ready), 64'(1 << k));
            tick();
            chk("t2_issue_ready_low", 64'(req_ready), 64'd0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk("t2_full_stall", 64'(req_ready), 64'd0);
            chk("t2_busy", 64'(busy), 64'd1);
            tick();
        end
        exp_resp.push_back('{2, 8'hA2});
        status(8'h02);
        #1;
        chk("t2_refill_grant", 64'(req_ready), 64'b0001);
        exp_desc.push_back('{16'h1000, 20'd0, 8'h02});
        tick();
        req_valid = '0;
        chk("t2_refill_valid", 64'(m_desc_valid), 64'd1);
        tick();

        // Five requests, no status: fifth waits for a freed slot
        do_reset("t3_reset");
        for (int p = 0; p < P; p++) begin
            send(p, AW'(16'h3000 + p), LW'(20'h10 + p), TW'(8'h10 + p), TW'(p));
        end
        set_req(1, 16'h2000, 20'h80, 8'h20);
        req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_fifth_blocked", 64'(req_ready), 64'd0);
            tick();
        end
        exp_resp.push_back('{1, 8'h11});
        status(8'h01);
        #1;
        chk("t3_fifth_grant", 64'(req_ready), 64'b0010);
        exp_desc.push_back('{16'h2000, 20'h80, 8'h01});
        tick();
        req_valid = '0;
        chk("t3_fifth_valid", 64'(m_desc_valid), 64'd1);
        tick();
        exp_resp.push_back('{0, 8'h10});
        status(8'h00);
        exp_resp.push_back('{2, 8'h12});
        status(8'h02);
        exp_resp.push_back('{3, 8'h13});
        status(8'h03);
        exp_resp.push_back('{1, 8'h20});
        status(8'h01);
        tick();
        chk("t3_all_free", 64'(busy), 64'd0);

        // Descriptor backpressure: fields stable, all ready low
        set_req(3, 16'hBEEF, 20'hABCDE, 8'h77);
        req_valid = 4'b1000;
        #1;
        chk("t4_grant", 64'(req_ready), 64'b1000);
        exp_desc.push_back('{16'hBEEF, 20'hABCDE, 8'h00});
        m_desc_ready = 1'b0;
        tick();
        req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t4_hold_valid", 64'(m_desc_valid), 64'd1);
            chk("t4_hold_fields", {m_desc_addr, m_desc_len, m_desc_tag},
                {16'hBEEF, 20'hABCDE, 8'h00});
            chk("t4_hold_ready_low", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid    = '0;
        m_desc_ready = 1'b1;
        tick();

        // Simultaneous free of slot 0 and allocation: must take slot 2
        send(0, 16'h4000, 20'h40, 8'h31, 8'h01);
        set_req(2, 16'h5000, 20'h50, 8'h42);
        req_valid      = 4'b0100;
        s_status_tag   = 8'h00;
        s_status_valid = 1'b1;
        exp_resp.push_back('{3, 8'h77});
        #1;
        chk("t5_grant", 64'(req_ready), 64'b0100);
        exp_desc.push_back('{16'h5000, 20'h50, 8'h02});
        tick();
        s_status_valid = 1'b0;
        req_valid      = '0;
        chk("t5_issue_valid", 64'(m_desc_valid), 64'd1);
        tick();
        send(1, 16'h6000, 20'h60, 8'h53, 8'h00);
        exp_resp.push_back('{0, 8'h31});
        status(8'h01);
        exp_resp.push_back('{2, 8'h42});
        status(8'h02);
        exp_resp.push_back('{1, 8'h53});
        status(8'h00);
        tick();
        chk("t5_all_free", 64'(busy), 64'd0);

        // Unknown tags
        chk("t6_err_clear", 64'(err_unknown_tag), 64'd0);
        status(8'h03);
        chk("t6_err_free_slot", 64'(err_unknown_tag), 64'd1);
        chk("t6_no_resp", 64'(resp_valid), 64'd0);
        tick();
        chk("t6_err_sticky", 64'(err_unknown_tag), 64'd1);
        do_reset("t6_reset");
        status(8'h05);
        chk("t6_err_range", 64'(err_unknown_tag), 64'd1);
        chk("t6_no_resp_range", 64'(resp_valid), 64'd0);

        // Reset during ISSUE drops the descriptor; its later status is unknown
        do_reset("t7_pre_reset");
        set_req(1, 16'h7000, 20'h70, 8'h66);
        req_valid    = 4'b0010;
        m_desc_ready = 1'b0;
        tick();
        req_valid = '0;
        chk("t7_in_issue", 64'(m_desc_valid), 64'd1);
        #2;
        do_reset("t7_mid_issue");
        m_desc_ready = 1'b1;
        status(8'h00);
        chk("t7_err_dropped", 64'(err_unknown_tag), 64'd1);
        chk("t7_no_resp", 64'(resp_valid), 64'd0);
        tick();

        chk("desc_queue_empty", 64'(exp_desc.size()), 64'd0);
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
